// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control: FSM states, ALU function
// codes and the opcode/funct encodings the decoders dispatch on.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_ALUWB    = 4'd5,
        ST_MEMADDR  = 4'd6,
        ST_MEMREAD  = 4'd7,
        ST_MEMWRITE = 4'd8,
        ST_MEMWB    = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JR       = 4'd12
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_BZ    = 6'h18;
    localparam logic [5:0] OPC_BN    = 6'h19;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decode: picks the execute-phase ALU function and the
// immediate extension mode for an instruction; flags unknown R-type functs.
module alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ext_op,
    output logic                funct_ok
);

    always_comb begin
        alu_op   = ALU_OP_W'(OP_ADD);
        ext_op   = 1'b1;
        funct_ok = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                ext_op   = 1'b0;
                funct_ok = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_OP_W'(OP_ADD);
                    FN_SUB:  alu_op = ALU_OP_W'(OP_SUB);
                    FN_AND:  alu_op = ALU_OP_W'(OP_AND);
                    FN_OR:   alu_op = ALU_OP_W'(OP_OR);
                    FN_NOR:  alu_op = ALU_OP_W'(OP_NOR);
                    FN_SLT:  alu_op = ALU_OP_W'(OP_SLT);
                    FN_SLL:  alu_op = ALU_OP_W'(OP_SLL);
                    FN_SRL:  alu_op = ALU_OP_W'(OP_SRL);
                    default: funct_ok = 1'b0;
                endcase
            end
            // Logical immediates are zero-extended, arithmetic ones sign-extended.
            OPC_ANDI: begin
                alu_op = ALU_OP_W'(OP_AND);
                ext_op = 1'b0;
            end
            OPC_ORI: begin
                alu_op = ALU_OP_W'(OP_OR);
                ext_op = 1'b0;
            end
            OPC_BEQ, OPC_BNE, OPC_BZ, OPC_BN: alu_op = ALU_OP_W'(OP_SUB);
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int ALU_OP_W      = 3,
    parameter bit ENABLE_LINK   = 1'b1,
    parameter bit ENABLE_STATUS = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] funct,
    input  logic                mem_ready,
    input  logic                zero,
    input  logic                st_z,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_select,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                write_reg31,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_op,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [3:0]          state
);

    state_t              state_r;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_ext_op;
    logic                funct_ok;

    logic is_r, is_jr, is_imm, is_lw, is_sw, is_branch, is_jal, is_jump, legal;
    logic branch_taken;

    alu_decoder #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_decoder (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_alu_op),
        .ext_op   (dec_ext_op),
        .funct_ok (funct_ok)
    );

    assign is_r      = (opcode == OPC_RTYPE);
    assign is_jr     = is_r && (funct == FN_JR);
    assign is_imm    = (opcode == OPC_ADDI) || (opcode == OPC_ANDI) || (opcode == OPC_ORI);
    assign is_lw     = (opcode == OPC_LW);
    assign is_sw     = (opcode == OPC_SW);
    assign is_branch = (opcode == OPC_BEQ) || (opcode == OPC_BNE) ||
                       (ENABLE_STATUS && ((opcode == OPC_BZ) || (opcode == OPC_BN)));
    assign is_jal    = ENABLE_LINK && (opcode == OPC_JAL);
    assign is_jump   = (opcode == OPC_J) || is_jal;
    assign legal     = is_r || is_imm || is_lw || is_sw || is_branch || is_jump;

    always_comb begin
        case (opcode)
            OPC_BEQ: branch_taken = zero;
            OPC_BNE: branch_taken = !zero;
            OPC_BZ:  branch_taken = st_z;
            OPC_BN:  branch_taken = !st_z;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:     state_r <= ST_FETCH;
                ST_FETCH:    if (mem_ready) state_r <= ST_DECODE;
                ST_DECODE: begin
                    if (!legal)         state_r <= ST_FETCH;
                    else if (is_jr)     state_r <= ST_JR;
                    else if (is_r)      state_r <= ST_EXEC_R;
                    else if (is_imm)    state_r <= ST_EXEC_I;
                    else if (is_lw || is_sw) state_r <= ST_MEMADDR;
                    else if (is_branch) state_r <= ST_BRANCH;
                    else                state_r <= ST_JUMP;
                end
                ST_EXEC_R:   state_r <= funct_ok ? ST_ALUWB : ST_FETCH;
                ST_EXEC_I:   state_r <= ST_ALUWB;
                ST_MEMADDR:  state_r <= is_lw ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  if (mem_ready) state_r <= ST_MEMWB;
                ST_MEMWRITE: if (mem_ready) state_r <= ST_FETCH;
                ST_ALUWB, ST_MEMWB, ST_BRANCH, ST_JUMP, ST_JR: state_r <= ST_FETCH;
                default:     state_r <= ST_IDLE;
            endcase
        end
    end

    assign state = state_r;

    // Decoded from the state register so an async reset clears every output at once.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_select     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        write_reg31   = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_op        = 1'b0;
        alu_op        = ALU_OP_W'(OP_ADD);
        illegal       = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                illegal   = !legal;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                illegal   = !funct_ok;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = dec_ext_op;
                alu_op    = dec_alu_op;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = !is_r;
            end
            ST_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            ST_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b1;
            end
            // pc_write carries the resolved condition so bne/bz/bn need no datapath logic.
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(OP_SUB);
                pc_write_cond = 1'b1;
                pc_select     = 2'b01;
                pc_write      = branch_taken;
            end
            ST_JUMP: begin
                pc_write    = 1'b1;
                pc_select   = 2'b10;
                reg_write   = is_jal;
                write_reg31 = is_jal;
            end
            ST_JR: begin
                pc_write  = 1'b1;
                pc_select = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
